// File: rtl/sc_count_scheduler.sv
// Shares one stochastic pulse counter across M bitstream channels, round-robin per window.
// Optional SC_CNT_SATURATE_EN makes the accumulator saturate instead of wrapping.
module sc_count_scheduler #(
    parameter int N  = 14,
    parameter int M  = 4,
    parameter int CW = 2,
    parameter int LW = 14
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [M-1:0]  REQ,
    input  logic [M-1:0]  SC_IN,
    input  logic [LW-1:0] WIN_LEN,
    output logic [M-1:0]  GNT,
    output logic [N-1:0]  RESULT,
    output logic [CW-1:0] RES_CH,
    output logic          RES_VALID,
    input  logic          RES_READY,
    output logic          BUSY
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [M-1:0]  gnt, gnt_nxt;
    logic [N-1:0]  result, result_nxt;
    logic [CW-1:0] res_ch, res_ch_nxt;
    logic          res_valid, res_valid_nxt;
    logic [N-1:0]  acc, acc_nxt, acc_inc;
    logic [LW-1:0] win_cnt, win_cnt_nxt;
    logic [CW-1:0] last_ch, last_ch_nxt;
    logic [CW-1:0] sel;
    logic          found;
    logic          sc_bit;
    int            idx;

    // Round-robin search starting just after the last granted channel
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 1; i <= M; i++) begin
            idx = (int'(last_ch) + i) % M;
            if (!found && REQ[idx[CW-1:0]]) begin
                found = 1'b1;
                sel   = idx[CW-1:0];
            end
        end
    end

    assign sc_bit = SC_IN[res_ch];

`ifdef SC_CNT_SATURATE_EN
    assign acc_inc = (&acc) ? acc : acc + N'(sc_bit);
`else
    assign acc_inc = acc + N'(sc_bit);
`endif

    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        result_nxt    = result;
        res_ch_nxt    = res_ch;
        res_valid_nxt = res_valid;
        acc_nxt       = acc;
        win_cnt_nxt   = win_cnt;
        last_ch_nxt   = last_ch;
        unique case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt     = M'(1) << sel;
                    res_ch_nxt  = sel;
                    acc_nxt     = '0;
                    win_cnt_nxt = WIN_LEN;
                    last_ch_nxt = sel;
                    if (WIN_LEN == '0) begin
                        result_nxt    = '0;
                        res_valid_nxt = 1'b1;
                        state_nxt     = DONE;
                    end else begin
                        state_nxt = COUNT;
                    end
                end
            end
            COUNT: begin
                acc_nxt     = acc_inc;
                win_cnt_nxt = win_cnt - LW'(1);
                if (win_cnt == LW'(1)) begin
                    result_nxt    = acc_inc;
                    res_valid_nxt = 1'b1;
                    state_nxt     = DONE;
                end
            end
            DONE: begin
                if (res_valid && RES_READY) begin
                    res_valid_nxt = 1'b0;
                    gnt_nxt       = '0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= IDLE;
            gnt       <= '0;
            result    <= '0;
            res_ch    <= '0;
            res_valid <= 1'b0;
            acc       <= '0;
            win_cnt   <= '0;
            last_ch   <= CW'(M - 1);
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            result    <= result_nxt;
            res_ch    <= res_ch_nxt;
            res_valid <= res_valid_nxt;
            acc       <= acc_nxt;
            win_cnt   <= win_cnt_nxt;
            last_ch   <= last_ch_nxt;
        end
    end

    assign GNT       = gnt;
    assign RESULT    = result;
    assign RES_CH    = res_ch;
    assign RES_VALID = res_valid;
    assign BUSY      = (state != IDLE);

endmodule

// File: tb/tb_sc_count_scheduler.sv
// Directed bench for sc_count_scheduler; a second N=4 instance covers overflow.
// Expected overflow result follows SC_CNT_SATURATE_EN.
module tb_sc_count_scheduler;

`ifdef SC_CNT_SATURATE_EN
    localparam int OVF_EXP = 15;
`else
    localparam int OVF_EXP = 4;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  sc_in;
    logic [13:0] win_len;
    logic        res_ready;
    logic [3:0]  gnt;
    logic [13:0] result;
    logic [1:0]  res_ch;
    logic        res_valid;
    logic        busy;
    logic [3:0]  gnt4;
    logic [3:0]  result4;
    logic [1:0]  res_ch4;
    logic        res_valid4;
    logic        busy4;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sc_count_scheduler u_dut (
        .CLK(clk), .RESET(reset), .REQ(req), .SC_IN(sc_in),
        .WIN_LEN(win_len), .GNT(gnt), .RESULT(result), .RES_CH(res_ch),
        .RES_VALID(res_valid), .RES_READY(res_ready), .BUSY(busy)
    );

    sc_count_scheduler #(.N(4)) u_dut_n4 (
        .CLK(clk), .RESET(reset), .REQ(req), .SC_IN(sc_in),
        .WIN_LEN(win_len), .GNT(gnt4), .RESULT(result4), .RES_CH(res_ch4),
        .RES_VALID(res_valid4), .RES_READY(res_ready), .BUSY(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!res_valid && n < max) begin
            tick();
            n++;
        end
        chk("valid_timeout", 32'(res_valid), 32'd1);
    endtask

    int gnt_cycles;
    int valid_cycles;
    int prev;
    logic [15:0] pat;
    int rr_a [6] = '{0, 1, 2, 3, 0, 1};
    int rr_b [4] = '{0, 1, 3, 0};

    initial begin
        reset = 1'b0; req = 4'b1111; sc_in = '0;
        win_len = 14'd4; res_ready = 1'b1;
        tick(); tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick();
        chk("rst_first_gnt", 32'(gnt), 32'b0001);
        req = '0;
        wait_valid(20);
        chk("rst_first_ch", 32'(res_ch), 32'd0);
        tick();

        // single channel, 10 ones out of 16
        pat = 16'b1101_1011_0110_1010;
        req = 4'b0010; win_len = 14'd16;
        tick();
        req = '0;
        gnt_cycles = (gnt == 4'b0010) ? 1 : 0;
        valid_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            sc_in = {i[0], ~i[0], pat[i], i[0]};
            tick();
            if (gnt == 4'b0010) gnt_cycles++;
            if (res_valid) valid_cycles++;
        end
        chk("single_result", 32'(result), 32'd10);
        chk("single_ch", 32'(res_ch), 32'd1);
        sc_in = '0;
        tick();
        if (gnt == 4'b0010) gnt_cycles++;
        if (res_valid) valid_cycles++;
        chk("single_gnt_cycles", 32'(gnt_cycles), 32'd17);
        chk("single_valid_cycles", 32'(valid_cycles), 32'd1);

        // round robin from reset, all requesting
        reset = 1'b0; tick();
        req = 4'b1111; win_len = 14'd4; reset = 1'b1;
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            wait_valid(20);
            chk("rr_ch", 32'(res_ch), 32'(rr_a[k]));
            if (k > 0) chk("rr_gap", 32'(cyc - prev), 32'd6);
            prev = cyc;
            tick();
        end
        reset = 1'b0; tick();
        req = 4'b1011; reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid(20);
            chk("rr_drop_ch", 32'(res_ch), 32'(rr_b[k]));
            tick();
        end
        req = '0;
        tick();

        // backpressure
        req = 4'b0100; win_len = 14'd3; sc_in = 4'b0100; res_ready = 1'b0;
        tick();
        req = 4'b1111;
        wait_valid(20);
        chk("bp_result", 32'(result), 32'd3);
        chk("bp_ch", 32'(res_ch), 32'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid_hold", 32'(res_valid), 32'd1);
            chk("bp_result_hold", 32'(result), 32'd3);
            chk("bp_ch_hold", 32'(res_ch), 32'd2);
            chk("bp_gnt_hold", 32'(gnt), 32'b0100);
        end
        res_ready = 1'b1;
        tick();
        req = '0;
        chk("bp_release_valid", 32'(res_valid), 32'd0);
        chk("bp_release_gnt", 32'(gnt), 32'd0);
        chk("bp_release_busy", 32'(busy), 32'd0);
        tick();

        // overflow on the N=4 instance
        req = 4'b0001; win_len = 14'd20; sc_in = 4'b0001;
        tick();
        req = '0;
        wait_valid(40);
        chk("ovf_wide", 32'(result), 32'd20);
        chk("ovf_n4_valid", 32'(res_valid4), 32'd1);
        chk("ovf_n4", 32'(result4), 32'(OVF_EXP));
        tick();
        sc_in = '0;

        // zero-length window
        req = 4'b1000; win_len = 14'd0;
        tick();
        req = '0;
        chk("zero_valid", 32'(res_valid), 32'd1);
        chk("zero_result", 32'(result), 32'd0);
        chk("zero_gnt", 32'(gnt), 32'b1000);
        chk("zero_ch", 32'(res_ch), 32'd3);
        tick();
        chk("zero_done", 32'(res_valid), 32'd0);

        // reset on the third COUNT cycle
        req = 4'b0010; win_len = 14'd8; sc_in = 4'b1111;
        tick();
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_valid", 32'(res_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        req = 4'b1111; reset = 1'b1;
        tick();
        chk("abort_regrant", 32'(gnt), 32'b0001);
        req = '0;
        wait_valid(20);
        chk("abort_after_ch", 32'(res_ch), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
